// File: rtl/oled_spi_master.sv
// oled_spi_master: parametrised SPI transmit master for the OLED path.
// Valid/ready word input, CS framing across bursts, latched D/C line.
module oled_spi_master #(
   parameter int unsigned HALF_PERIOD = 100,
   parameter int unsigned WIDTH       = 8,
   parameter bit          CPOL        = 1'b1,
   parameter bit          CPHA        = 1'b1,
   parameter bit          LSB_FIRST   = 1'b0,
   parameter int unsigned CS_GAP      = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             tx_valid,
   output logic             tx_ready,
   input  logic [WIDTH-1:0] tx_data,
   input  logic             tx_dc,
   input  logic             tx_last,
   output logic             busy,
   output logic             sclk,
   output logic             sdo,
   output logic             cs_n,
   output logic             dc
);

   localparam int unsigned HPW = $clog2(HALF_PERIOD + 1);
   localparam int unsigned EW  = $clog2(2 * WIDTH + 1);
   localparam int unsigned GW  = $clog2(CS_GAP + 1);

   localparam logic [HPW-1:0] HP_END = HPW'(HALF_PERIOD - 1);
   localparam logic [EW-1:0]  E_LAST = EW'(2 * WIDTH - 1);
   localparam logic [GW-1:0]  G_END  = GW'(CS_GAP - 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_SETUP = 3'd1;
   localparam logic [2:0] S_SHIFT = 3'd2;
   localparam logic [2:0] S_HOLD  = 3'd3;
   localparam logic [2:0] S_GAP   = 3'd4;

   logic [2:0]       state_q, state_d;
   logic [HPW-1:0]   hp_q, hp_d;
   logic [EW-1:0]    e_q, e_d;
   logic [GW-1:0]    g_q, g_d;
   logic [WIDTH-1:0] sh_q, sh_d;
   logic             last_q, last_d;
   logic             sclk_q, sclk_d;
   logic             sdo_q, sdo_d;
   logic             cs_n_q, cs_n_d;
   logic             dc_q, dc_d;
   logic             hp_end;

   function automatic logic first_bit(input logic [WIDTH-1:0] w);
      return LSB_FIRST ? w[0] : w[WIDTH-1];
   endfunction

   function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
      return LSB_FIRST ? (w >> 1) : (w << 1);
   endfunction

   assign hp_end   = (hp_q == HP_END);
   assign tx_ready = en && (state_q == S_IDLE);
   assign busy     = (state_q != S_IDLE);
   assign sclk     = sclk_q;
   assign sdo      = sdo_q;
   assign cs_n     = cs_n_q;
   assign dc       = dc_q;

   // Next-state: framing FSM, half-period timing and bit shifting.
   always_comb begin
      state_d = state_q;
      hp_d    = hp_q;
      e_d     = e_q;
      g_d     = g_q;
      sh_d    = sh_q;
      last_d  = last_q;
      sclk_d  = sclk_q;
      sdo_d   = sdo_q;
      cs_n_d  = cs_n_q;
      dc_d    = dc_q;
      if (!en) begin
         state_d = S_IDLE;
         hp_d    = '0;
         e_d     = '0;
         g_d     = '0;
         sclk_d  = CPOL;
         sdo_d   = 1'b0;
         cs_n_d  = 1'b1;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (tx_valid) begin
                  sh_d    = tx_data;
                  last_d  = tx_last;
                  dc_d    = tx_dc;
                  cs_n_d  = 1'b0;
                  hp_d    = '0;
                  e_d     = '0;
                  state_d = S_SETUP;
                  if (!CPHA) sdo_d = first_bit(tx_data);
               end
            end
            S_SETUP: begin
               if (hp_end) begin
                  hp_d    = '0;
                  state_d = S_SHIFT;
               end else begin
                  hp_d = hp_q + HPW'(1);
               end
            end
            S_SHIFT: begin
               if (hp_end) begin
                  hp_d   = '0;
                  sclk_d = ~sclk_q;
                  e_d    = e_q + EW'(1);
                  // e_q holds the count of edges already made.
                  if (CPHA) begin
                     if (!e_q[0]) begin
                        sdo_d = first_bit(sh_q);
                        sh_d  = advance(sh_q);
                     end
                  end else begin
                     if (e_q[0] && (e_q != E_LAST)) begin
                        sh_d  = advance(sh_q);
                        sdo_d = first_bit(advance(sh_q));
                     end
                  end
                  if (e_q == E_LAST) begin
                     e_d     = '0;
                     state_d = S_HOLD;
                  end
               end else begin
                  hp_d = hp_q + HPW'(1);
               end
            end
            S_HOLD: begin
               if (hp_end) begin
                  hp_d = '0;
                  if (last_q) begin
                     cs_n_d  = 1'b1;
                     g_d     = '0;
                     state_d = S_GAP;
                  end else begin
                     state_d = S_IDLE;
                  end
               end else begin
                  hp_d = hp_q + HPW'(1);
               end
            end
            S_GAP: begin
               if (g_q == G_END) begin
                  g_d     = '0;
                  state_d = S_IDLE;
               end else begin
                  g_d = g_q + GW'(1);
               end
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   // State and pin registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         hp_q    <= '0;
         e_q     <= '0;
         g_q     <= '0;
         sh_q    <= '0;
         last_q  <= 1'b0;
         sclk_q  <= CPOL;
         sdo_q   <= 1'b0;
         cs_n_q  <= 1'b1;
         dc_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         hp_q    <= hp_d;
         e_q     <= e_d;
         g_q     <= g_d;
         sh_q    <= sh_d;
         last_q  <= last_d;
         sclk_q  <= sclk_d;
         sdo_q   <= sdo_d;
         cs_n_q  <= cs_n_d;
         dc_q    <= dc_d;
      end
   end

endmodule
